// File: rtl/ddr2_ras_pkg.sv
// Shared definitions for the DDR2 RAS error-log poller: CSR offsets,
// the log entry layout and the read-sequence state encoding.
package ddr2_ras_pkg;

  localparam logic [7:0] RAS_TOTC   = 8'h00;
  localparam logic [7:0] RAS_TOTU   = 8'h04;
  localparam logic [7:0] RAS_CTX    = 8'h08;
  localparam logic [7:0] RAS_ADDR   = 8'h0C;
  localparam logic [7:0] RAS_STATUS = 8'h20;

  typedef struct packed {
    logic        err_type;
    logic [3:0]  rank;
    logic [7:0]  syndrome;
    logic [31:0] addr;
    logic [31:0] totc;
    logic [31:0] totu;
  } ras_log_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_TOTC = 3'd1,
    ST_RD_TOTU = 3'd2,
    ST_RD_CTX  = 3'd3,
    ST_RD_ADDR = 3'd4,
    ST_COMMIT  = 3'd5
  } ras_state_e;

  function automatic ras_log_entry_t ras_make_entry(
    input logic        err_type,
    input logic [3:0]  rank,
    input logic [7:0]  syndrome,
    input logic [31:0] addr,
    input logic [31:0] totc,
    input logic [31:0] totu
  );
    ras_log_entry_t e;
    e.err_type = err_type;
    e.rank     = rank;
    e.syndrome = syndrome;
    e.addr     = addr;
    e.totc     = totc;
    e.totu     = totu;
    return e;
  endfunction

endpackage

// File: rtl/ddr2_ras_log_fifo.sv
// First-word-fall-through FIFO of RAS log entries; push while full is
// accepted only when the head is popped in the same cycle.
module ddr2_ras_log_fifo
  import ddr2_ras_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           push_i,
  input  ras_log_entry_t entry_i,
  input  logic           pop_i,
  output ras_log_entry_t head_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  ras_log_entry_t mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [AW:0]    count_q;
  logic           do_push_s;
  logic           do_pop_s;

  assign do_pop_s  = pop_i & (count_q != {(AW+1){1'b0}});
  assign do_push_s = push_i & ((count_q != CNT_FULL) | do_pop_s);

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == {(AW+1){1'b0}});

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ddr2_ras_log_poller.sv
// Walks the RAS ECC CSRs on an IRQ edge or poll-timer expiry and logs an
// entry into a FWFT FIFO when the totals changed or an IRQ forced the read.
module ddr2_ras_log_poller
  import ddr2_ras_pkg::*;
#(
  parameter int ADDR_WIDTH    = 25,
  parameter int POLL_INTERVAL = 1024,
  parameter int LOG_DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  poll_enable,
  input  logic                  irq_ecc_corr,
  input  logic                  irq_ecc_uncorr,
  output logic [7:0]            reg_addr,
  input  logic [31:0]           reg_data_in,
  output logic                  log_valid,
  input  logic                  log_ready,
  output logic                  log_type,
  output logic [3:0]            log_rank,
  output logic [7:0]            log_syndrome,
  output logic [ADDR_WIDTH-1:0] log_addr,
  output logic [31:0]           log_total_corr,
  output logic [31:0]           log_total_uncorr,
  output logic [15:0]           overflow_cnt,
  output logic                  busy
);

  localparam int TW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(POLL_INTERVAL - 1);
  localparam logic [TW-1:0] TIMER_ONE    = TW'(1);

  ras_state_e            state_q;
  logic [7:0]            reg_addr_q;
  logic                  busy_q;
  logic                  forced_q;
  logic [31:0]           totc_q;
  logic [31:0]           totu_q;
  logic                  ctx_type_q;
  logic [3:0]            ctx_rank_q;
  logic [7:0]            ctx_syn_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           last_corr_q;
  logic [31:0]           last_uncorr_q;
  logic [15:0]           ovf_q;
  logic [TW-1:0]         timer_q;
  logic [TW-1:0]         timer_d;
  logic                  poll_pend_q;
  logic                  poll_pend_d;
  logic                  irq_pend_q;
  logic                  irq_pend_d;
  logic                  irq_corr_q;
  logic                  irq_uncorr_q;

  logic                  poll_fire_s;
  logic                  irq_rise_s;
  logic                  start_s;
  logic                  produce_s;
  logic                  push_s;
  logic                  drop_s;
  logic                  pop_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  ras_log_entry_t        entry_s;
  ras_log_entry_t        head_s;
  logic                  unused_addr_s;

  // Poll timer next state: counts down only while enabled, fires at zero
  always_comb begin
    timer_d     = timer_q;
    poll_fire_s = 1'b0;
    if (poll_enable) begin
      if (timer_q == {TW{1'b0}}) begin
        timer_d     = TIMER_RELOAD;
        poll_fire_s = 1'b1;
      end else begin
        timer_d     = timer_q - TIMER_ONE;
        poll_fire_s = 1'b0;
      end
    end else begin
      timer_d     = timer_q;
      poll_fire_s = 1'b0;
    end
  end

  assign irq_rise_s = (irq_ecc_corr & ~irq_corr_q) | (irq_ecc_uncorr & ~irq_uncorr_q);
  assign start_s    = (state_q == ST_IDLE) & (irq_pend_q | poll_pend_q);
  // A new event in the same cycle a sequence starts must not be lost
  assign irq_pend_d  = (irq_pend_q & ~start_s) | irq_rise_s;
  assign poll_pend_d = (poll_pend_q & ~start_s) | poll_fire_s;

  assign produce_s = (state_q == ST_COMMIT) &
                     (forced_q | (totc_q != last_corr_q) | (totu_q != last_uncorr_q));
  assign pop_s     = ~fifo_empty_s & log_ready;
  assign push_s    = produce_s & (~fifo_full_s | pop_s);
  assign drop_s    = produce_s & fifo_full_s & ~pop_s;

  assign entry_s = ras_make_entry(ctx_type_q, ctx_rank_q, ctx_syn_q,
                                  32'(addr_q), totc_q, totu_q);

  // Trigger sources: timer, pend flags and IRQ edge history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q      <= TIMER_RELOAD;
      poll_pend_q  <= 1'b0;
      irq_pend_q   <= 1'b0;
      irq_corr_q   <= 1'b0;
      irq_uncorr_q <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      poll_pend_q  <= poll_pend_d;
      irq_pend_q   <= irq_pend_d;
      irq_corr_q   <= irq_ecc_corr;
      irq_uncorr_q <= irq_ecc_uncorr;
    end
  end

  // CSR read sequencer with registered address and busy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      reg_addr_q    <= RAS_TOTC;
      busy_q        <= 1'b0;
      forced_q      <= 1'b0;
      totc_q        <= 32'd0;
      totu_q        <= 32'd0;
      ctx_type_q    <= 1'b0;
      ctx_rank_q    <= 4'd0;
      ctx_syn_q     <= 8'd0;
      addr_q        <= {ADDR_WIDTH{1'b0}};
      last_corr_q   <= 32'd0;
      last_uncorr_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_s) begin
            state_q    <= ST_RD_TOTC;
            reg_addr_q <= RAS_TOTC;
            busy_q     <= 1'b1;
            forced_q   <= irq_pend_q;
          end
        end
        ST_RD_TOTC: begin
          totc_q     <= reg_data_in;
          state_q    <= ST_RD_TOTU;
          reg_addr_q <= RAS_TOTU;
        end
        ST_RD_TOTU: begin
          totu_q     <= reg_data_in;
          state_q    <= ST_RD_CTX;
          reg_addr_q <= RAS_CTX;
        end
        ST_RD_CTX: begin
          ctx_type_q <= reg_data_in[31];
          ctx_rank_q <= reg_data_in[15:12];
          ctx_syn_q  <= reg_data_in[7:0];
          state_q    <= ST_RD_ADDR;
          reg_addr_q <= RAS_ADDR;
        end
        ST_RD_ADDR: begin
          addr_q     <= reg_data_in[ADDR_WIDTH-1:0];
          state_q    <= ST_COMMIT;
          reg_addr_q <= RAS_TOTC;
        end
        ST_COMMIT: begin
          // Dropped entries still advance the baseline so a full FIFO cannot re-log them
          if (produce_s) begin
            last_corr_q   <= totc_q;
            last_uncorr_q <= totu_q;
          end
          state_q    <= ST_IDLE;
          reg_addr_q <= RAS_TOTC;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          reg_addr_q <= RAS_TOTC;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of entries lost to a full FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 16'd0;
    end else if (drop_s && (ovf_q != 16'hFFFF)) begin
      ovf_q <= ovf_q + 16'd1;
    end
  end

  ddr2_ras_log_fifo #(
    .DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_s),
    .entry_i (entry_s),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign unused_addr_s = |(head_s.addr >> ADDR_WIDTH);

  assign reg_addr         = reg_addr_q;
  assign busy             = busy_q;
  assign overflow_cnt     = ovf_q;
  assign log_valid        = ~fifo_empty_s;
  assign log_type         = head_s.err_type;
  assign log_rank         = head_s.rank;
  assign log_syndrome     = head_s.syndrome;
  assign log_addr         = head_s.addr[ADDR_WIDTH-1:0];
  assign log_total_corr   = head_s.totc;
  assign log_total_uncorr = head_s.totu;

endmodule

// File: tb/tb_ddr2_ras_log_poller.sv
// Directed bench for ddr2_ras_log_poller with a combinational RAS CSR model
// and hand-computed expectations.
module tb_ddr2_ras_log_poller;

  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          poll_enable;
  logic          irq_ecc_corr;
  logic          irq_ecc_uncorr;
  logic [7:0]    reg_addr;
  logic [31:0]   reg_data_in;
  logic          log_valid;
  logic          log_ready;
  logic          log_type;
  logic [3:0]    log_rank;
  logic [7:0]    log_syndrome;
  logic [AW-1:0] log_addr;
  logic [31:0]   log_total_corr;
  logic [31:0]   log_total_uncorr;
  logic [15:0]   overflow_cnt;
  logic          busy;

  logic [31:0] m_totc, m_totu, m_ctx, m_addr;
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int b1, b2;

  ddr2_ras_log_poller #(
    .ADDR_WIDTH    (AW),
    .POLL_INTERVAL (16),
    .LOG_DEPTH     (4)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .poll_enable      (poll_enable),
    .irq_ecc_corr     (irq_ecc_corr),
    .irq_ecc_uncorr   (irq_ecc_uncorr),
    .reg_addr         (reg_addr),
    .reg_data_in      (reg_data_in),
    .log_valid        (log_valid),
    .log_ready        (log_ready),
    .log_type         (log_type),
    .log_rank         (log_rank),
    .log_syndrome     (log_syndrome),
    .log_addr         (log_addr),
    .log_total_corr   (log_total_corr),
    .log_total_uncorr (log_total_uncorr),
    .overflow_cnt     (overflow_cnt),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (reg_addr)
      8'h00:   reg_data_in = m_totc;
      8'h04:   reg_data_in = m_totu;
      8'h08:   reg_data_in = m_ctx;
      8'h0C:   reg_data_in = m_addr;
      default: reg_data_in = 32'd0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_busy(input logic lvl, input int max_cyc, input string tag);
    int n = 0;
    while (busy !== lvl && n < max_cyc) begin
      step(1);
      n++;
    end
    check_eq(tag, {31'd0, busy}, {31'd0, lvl});
  endtask

  task automatic pop_one();
    log_ready = 1'b1;
    step(1);
    log_ready = 1'b0;
  endtask

  task automatic pulse_corr();
    irq_ecc_corr = 1'b1;
    step(1);
    irq_ecc_corr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; poll_enable = 1'b0; irq_ecc_corr = 1'b0; irq_ecc_uncorr = 1'b0;
    log_ready = 1'b0;
    m_totc = 32'd0; m_totu = 32'd0; m_ctx = 32'd0; m_addr = 32'd0;
    step(3);
    check_eq("rst_reg_addr", {24'd0, reg_addr}, 32'h00);
    check_eq("rst_log_valid", {31'd0, log_valid}, 32'd0);
    check_eq("rst_overflow", {16'd0, overflow_cnt}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);

    // Periodic poll with all-zero CSRs
    reset_n = 1'b1;
    poll_enable = 1'b1;
    wait_busy(1'b1, 40, "poll1_start");
    b1 = cyc;
    check_eq("seq_addr0", {24'd0, reg_addr}, 32'h00);
    step(1);
    check_eq("seq_addr1", {24'd0, reg_addr}, 32'h04);
    step(1);
    check_eq("seq_addr2", {24'd0, reg_addr}, 32'h08);
    step(1);
    check_eq("seq_addr3", {24'd0, reg_addr}, 32'h0C);
    wait_busy(1'b0, 10, "poll1_end");
    check_eq("zero_no_entry", {31'd0, log_valid}, 32'd0);
    wait_busy(1'b1, 20, "poll2_start");
    b2 = cyc;
    check_eq("poll_period", b2 - b1, 32'd16);

    // Changed totals picked up by the next poll
    wait_busy(1'b0, 10, "poll2_end");
    m_totc = 32'd1; m_ctx = 32'h0000_105A; m_addr = 32'h0012_3456;
    wait_busy(1'b1, 20, "poll3_start");
    step(4);
    check_eq("commit_not_yet_valid", {31'd0, log_valid}, 32'd0);
    step(1);
    check_eq("entry_valid_t6", {31'd0, log_valid}, 32'd1);
    check_eq("entry_type", {31'd0, log_type}, 32'd0);
    check_eq("entry_rank", {28'd0, log_rank}, 32'd1);
    check_eq("entry_syn", {24'd0, log_syndrome}, 32'h5A);
    check_eq("entry_addr", {7'd0, log_addr}, 32'h0012_3456);
    check_eq("entry_totc", log_total_corr, 32'd1);
    check_eq("entry_totu", log_total_uncorr, 32'd0);
    pop_one();
    check_eq("popped_empty", {31'd0, log_valid}, 32'd0);

    // Forced entry from an uncorrectable IRQ edge with unchanged totals
    poll_enable = 1'b0;
    step(10);
    check_eq("idle_before_irq", {31'd0, busy}, 32'd0);
    m_ctx = 32'h8000_2033;
    irq_ecc_uncorr = 1'b1;
    step(6);
    check_eq("irq_not_yet_valid", {31'd0, log_valid}, 32'd0);
    step(1);
    check_eq("irq_entry_valid", {31'd0, log_valid}, 32'd1);
    check_eq("irq_entry_type", {31'd0, log_type}, 32'd1);
    check_eq("irq_entry_rank", {28'd0, log_rank}, 32'd2);
    check_eq("irq_entry_syn", {24'd0, log_syndrome}, 32'h33);
    check_eq("irq_entry_totc", log_total_corr, 32'd1);
    pop_one();
    begin
      int busy_seen = 0;
      for (int i = 0; i < 40; i++) begin
        step(1);
        if (busy) busy_seen++;
      end
      check_eq("level_no_retrigger", busy_seen, 32'd0);
      check_eq("level_no_entry", {31'd0, log_valid}, 32'd0);
    end
    irq_ecc_uncorr = 1'b0;

    // Six forced entries into a four-deep FIFO with no consumer
    for (int i = 0; i < 6; i++) begin
      m_totc = 32'd10 + 32'(i);
      pulse_corr();
      step(8);
    end
    check_eq("ovf_count", {16'd0, overflow_cnt}, 32'd2);
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_valid", {31'd0, log_valid}, 32'd1);
      check_eq("drain_order", log_total_corr, 32'd10 + 32'(i));
      pop_one();
    end
    check_eq("drain_empty", {31'd0, log_valid}, 32'd0);

    // IRQ during RD_CTX queues a second forced sequence
    pulse_corr();
    step(1);
    check_eq("s5_totc_state", {31'd0, busy}, 32'd1);
    step(2);
    check_eq("s5_in_ctx", {24'd0, reg_addr}, 32'h08);
    irq_ecc_uncorr = 1'b1;
    step(1);
    m_ctx = 32'h0000_30C3;
    step(2);
    check_eq("s5_idle_gap", {31'd0, busy}, 32'd0);
    step(1);
    check_eq("s5_restart", {31'd0, busy}, 32'd1);
    step(5);
    check_eq("s5_first_valid", {31'd0, log_valid}, 32'd1);
    check_eq("s5_first_syn", {24'd0, log_syndrome}, 32'h33);
    pop_one();
    check_eq("s5_second_valid", {31'd0, log_valid}, 32'd1);
    check_eq("s5_second_syn", {24'd0, log_syndrome}, 32'hC3);
    check_eq("s5_second_rank", {28'd0, log_rank}, 32'd3);
    check_eq("s5_second_type", {31'd0, log_type}, 32'd0);
    irq_ecc_uncorr = 1'b0;

    // Asynchronous reset in RD_TOTU
    step(2);
    pulse_corr();
    step(1);
    check_eq("s6_busy", {31'd0, busy}, 32'd1);
    step(1);
    check_eq("s6_in_totu", {24'd0, reg_addr}, 32'h04);
    check_eq("s6_fifo_nonempty", {31'd0, log_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("s6_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("s6_rst_addr", {24'd0, reg_addr}, 32'h00);
    check_eq("s6_rst_valid", {31'd0, log_valid}, 32'd0);
    check_eq("s6_rst_ovf", {16'd0, overflow_cnt}, 32'd0);
    step(2);
    reset_n = 1'b1;
    step(10);
    check_eq("s6_no_partial", {31'd0, log_valid}, 32'd0);
    check_eq("s6_still_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr2_ras_log_poller.md
# ddr2_ras_log_poller

Initiator side of the RAS CSR read port. Walks the ECC error registers (totals, last-error context, last-error address) when an ECC interrupt rises or a periodic poll timer expires. Pushes a timestamp-free error-log entry into a small FIFO for host or firmware drain whenever the counts have changed. Sits between the RAS register block and the host-facing status path.

## Interface
- `ADDR_WIDTH`, 25: width of the logged error address.
- `POLL_INTERVAL`, 1024: poll period in clk cycles; must be ≥ 8.
- `LOG_DEPTH`, 4: log FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `poll_enable`  in  1  enables the poll timer. IRQ-triggered reads run regardless.
- `irq_ecc_corr`  in  1  level interrupt, correctable threshold exceeded.
- `irq_ecc_uncorr`  in  1  level interrupt, uncorrectable error.
- `reg_addr`  out  8  CSR read address (registered).
- `reg_data_in`  in  32  CSR read data; combinational from `reg_addr` in the same cycle.
- `log_valid`  out  1  FIFO head entry valid.
- `log_ready`  in  1  consumer accepts the head entry.
- `log_type`  out  1  0 = single-bit, 1 = double-bit (bit 31 of 0x08).
- `log_rank`  out  4  bits 15:12 of 0x08.
- `log_syndrome`  out  8  bits 7:0 of 0x08.
- `log_addr`  out  `ADDR_WIDTH`  0x0C[ADDR_WIDTH-1:0].
- `log_total_corr`  out  32  value read from 0x00.
- `log_total_uncorr`  out  32  value read from 0x04.
- `overflow_cnt`  out  16  entries dropped on full FIFO; saturates at 0xFFFF.
- `busy`  out  1  read sequence in progress (state ≠ IDLE).

## Operation
- Reset values: `reg_addr`=0x00, `log_valid`=0, `overflow_cnt`=0, `busy`=0. FIFO is emptied, pending flags are cleared, and last-logged totals are 0. Timer loads POLL_INTERVAL-1.
- IRQ edge detect: register both IRQs; a 0→1 transition on either sets `irq_pend`.
- Poll timer:
  - Decrements while `poll_enable`=1.
  - At 0 it sets `poll_pend` and reloads POLL_INTERVAL-1.
  - `poll_enable`=0 holds the count.
- FSM states: IDLE → RD_TOTC → RD_TOTU → RD_CTX → RD_ADDR → COMMIT → IDLE.
- IDLE leaves when `irq_pend` or `poll_pend` is set. That transition latches `forced`=`irq_pend` and clears both pend flags.
- Each RD state drives its `reg_addr` (0x00, 0x04, 0x08, 0x0C) for exactly one cycle and captures `reg_data_in` at the end of that cycle.
- COMMIT produces an entry when `forced`=1 OR totc≠last_corr OR totu≠last_uncorr.
  - Producing an entry updates last_corr and last_uncorr, whether the entry is pushed or dropped.
  - If the FIFO is full and not popping this cycle: drop the entry and increment `overflow_cnt` (saturating).
- Events arriving while `busy`=1 set the pend flags. Another sequence starts on the cycle after the return to IDLE.
- Both pend sources active together produce one sequence.
- FIFO is first-word-fall-through:
  - Head fields are valid when `log_valid`=1 and are don't-care otherwise.
  - A pop occurs on `log_valid & log_ready`.
  - Push and pop in the same cycle are legal when full or when empty. When empty, the pushed entry appears next cycle.

## Timing
- Trigger (pend set) visible at cycle T. Then RD_TOTC at T+1, RD_TOTU T+2, RD_CTX T+3, RD_ADDR T+4, COMMIT T+5.
- Entry is visible on `log_valid` at T+6 when the FIFO was empty.
- The IRQ edge is registered once: an IRQ input rising at cycle E sets `irq_pend` at E+1.
- `reg_addr` changes only on state transitions. It returns to 0x00 in IDLE.
- Minimum spacing between sequences: 6 cycles (5 busy plus 1 IDLE).
- Asynchronous reset mid-sequence aborts immediately. No partial entry is pushed.

## Structure
- Package `ddr2_ras_pkg` holds:
  - CSR offset constants (`RAS_TOTC`=0x00, `RAS_TOTU`=0x04, `RAS_CTX`=0x08, `RAS_ADDR`=0x0C, `RAS_STATUS`=0x20).
  - A `ras_log_entry_t` struct with type, rank, syndrome, addr, totc and totu fields.
  - The FSM state enum.
- Sub-module `ddr2_ras_log_fifo`: parameterized FWFT FIFO of `ras_log_entry_t` with `full`/`empty`, instantiated once.
- Poller FSM, timer, edge detect and overflow counter live in the top.

## Test plan
- Reset, then `poll_enable`=1, POLL_INTERVAL=16, RAS model returning zeros: `reg_addr` sequence 00,04,08,0C every 16 cycles, and no entry pushed.
- Model sets totc=1, ctx=0x0000_1_5A, addr=0x123456, then a poll fires: one entry with type 0, rank 1, syndrome 0x5A, addr 0x123456, totc 1. `log_valid` asserts 6 cycles after the trigger.
- `irq_ecc_uncorr` 0→1 with `poll_enable`=0 and unchanged totals: forced entry pushed. The level held high causes no further entries.
- Hold `log_ready`=0 and force 6 changes with LOG_DEPTH=4: 4 entries retained, `overflow_cnt`=2. Draining returns them in order.
- IRQ rises during RD_CTX: the current sequence completes, and a second sequence starts at COMMIT+2 with `forced`=1.
- Deassert `reset_n` in RD_TOTU: `busy`=0, `reg_addr`=0x00, `log_valid`=0 immediately.
